serial_sub: RTL

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/sub_pkg.sv | 15 +
 rtl/serial_sub_if.sv | 33 +++
 rtl/fullsub.sv | 14 +
 rtl/serial_sub.sv | 102 ++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
`default_nettype none
// sub_pkg: shared constants and FSM encoding for the bit-serial subtractor.
// Rev 1.0
package sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_sub_if.sv
`default_nettype none
// serial_sub_if: request/result bundle of serial_sub; bout present only with SUB_BORROW_EN.
// Rev 1.0
interface serial_sub_if #(
  parameter int WIDTH = sub_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
`ifdef SUB_BORROW_EN
  logic             bout;
`endif

  modport master (
    output start, a, b,
`ifdef SUB_BORROW_EN
    input  bout,
`endif
    input  busy, done, q
  );

  modport slave (
    input  start, a, b,
`ifdef SUB_BORROW_EN
    output bout,
`endif
    output busy, done, q
  );
endinterface
`default_nettype wire

// File: rtl/fullsub.sv
`default_nettype none
// fullsub: combinational one-bit full subtractor, D = A - B - BIN.
// Rev 1.0
module fullsub (
  input  logic A,
  input  logic B,
  input  logic BIN,
  output logic D,
  output logic BOUT
);
  assign D    = A ^ B ^ BIN;
  assign BOUT = (~A & B) | (~(A ^ B) & BIN);
endmodule
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// serial_sub: LSB-first bit-serial a - b, one bit per clock; SUB_BORROW_EN adds bout.
// Rev 1.0
module serial_sub
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  serial_sub_if.slave bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] ar;
  logic [WIDTH-1:0] br;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_next;
  logic [WIDTH-1:0] q_r;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic             diff;
  logic             borrow_next;
  logic             last_bit;

  fullsub u_fullsub (
    .A    (ar[0]),
    .B    (br[0]),
    .BIN  (borrow),
    .D    (diff),
    .BOUT (borrow_next)
  );

  // The final bit is folded in on the same edge that loads q.
  assign work_next = {diff, work[WIDTH-1:1]};
  assign last_bit  = (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last_bit)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar     <= '0;
      br     <= '0;
      work   <= '0;
      q_r    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            ar     <= bus.a;
            br     <= bus.b;
            cnt    <= '0;
            borrow <= 1'b0;
          end
        end
        SHIFT: begin
          work   <= work_next;
          ar     <= ar >> 1;
          br     <= br >> 1;
          borrow <= borrow_next;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) q_r <= work_next;
        end
        default: ;
      endcase
    end
  end

`ifdef SUB_BORROW_EN
  logic bout_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            bout_r <= 1'b0;
    else if (state == SHIFT && last_bit) bout_r <= borrow_next;
  end

  assign bus.bout = bout_r;
`endif

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.q    = q_r;
endmodule
`default_nettype wire
